// File: rtl/ad9226_sample.sv
`default_nettype none
// ============================================================================
//  Module   : ad9226_sample
//  Purpose  : AD9226 capture front-end. Narrows 12-bit ADC words to 8 bits,
//             detects a rising crossing of a trigger level, writes a burst of
//             SAMPLE_LEN samples to a display buffer, then holds off for
//             HOLDOFF cycles before re-arming.
//  Revision : 1.0  initial release
// ============================================================================
module ad9226_sample #(
  parameter int unsigned SAMPLE_LEN = 1024,
  parameter int unsigned TRIG_LEVEL = 127,
  parameter int unsigned HOLDOFF    = 25_000_000
) (
  input  logic        adc_clk,
  input  logic        rst,
  input  logic [11:0] adc_data,
  output logic        adc_buf_wr,
  output logic [11:0] adc_buf_addr,
  output logic [7:0]  adc_buf_data,
  output logic [7:0]  adc_data_narrow,
  output logic [7:0]  adc_data_narrow_d0
);

  localparam logic [1:0]  c_st_idle     = 2'd0;
  localparam logic [1:0]  c_st_sample   = 2'd1;
  localparam logic [1:0]  c_st_wait     = 2'd2;

  localparam logic [7:0]  c_trig_level  = 8'(TRIG_LEVEL);
  localparam logic [11:0] c_sample_last = 12'(SAMPLE_LEN - 1);
  localparam logic [31:0] c_wait_last   = 32'(HOLDOFF - 1);

  logic [1:0]  state_q,      state_d;
  logic [11:0] sample_cnt_q, sample_cnt_d;
  logic [31:0] wait_cnt_q,   wait_cnt_d;
  logic        wr_q,         wr_d;
  logic [11:0] addr_q,       addr_d;
  logic [7:0]  data_q,       data_d;
  logic [7:0]  narrow_q,     narrow_d;
  logic [7:0]  narrow_d0_q,  narrow_d0_d;
  logic        trig;

  // The four LSBs are dropped by design (plain truncation, no rounding).
  logic [3:0]  unused_adc_lsbs;
  assign unused_adc_lsbs = adc_data[3:0];

  // Narrowing pipeline runs every cycle, independent of the capture state.
  always_comb begin
    narrow_d    = adc_data[11:4];
    narrow_d0_d = narrow_q;
  end

  // Rising crossing: previous sample below the level, current at or above it.
  assign trig = (narrow_d0_q < c_trig_level) && (narrow_q >= c_trig_level);

  // Capture state machine: arm, burst-write, hold off.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    wr_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    case (state_q)
      c_st_idle: begin
        if (trig) begin
          state_d      = c_st_sample;
          sample_cnt_d = 12'd0;
        end
      end
      c_st_sample: begin
        wr_d   = 1'b1;
        addr_d = sample_cnt_q;
        data_d = narrow_q;
        if (sample_cnt_q == c_sample_last) begin
          state_d    = c_st_wait;
          wait_cnt_d = 32'd0;
        end else begin
          sample_cnt_d = sample_cnt_q + 12'd1;
        end
      end
      c_st_wait: begin
        wait_cnt_d = wait_cnt_q + 32'd1;
        if (wait_cnt_q == c_wait_last) begin
          state_d = c_st_idle;
        end
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // State and output registers; reset aborts any burst in progress.
  always_ff @(posedge adc_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= c_st_idle;
      sample_cnt_q <= 12'd0;
      wait_cnt_q   <= 32'd0;
      wr_q         <= 1'b0;
      addr_q       <= 12'd0;
      data_q       <= 8'd0;
      narrow_q     <= 8'd0;
      narrow_d0_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      narrow_q     <= narrow_d;
      narrow_d0_q  <= narrow_d0_d;
    end
  end

  assign adc_buf_wr         = wr_q;
  assign adc_buf_addr       = addr_q;
  assign adc_buf_data       = data_q;
  assign adc_data_narrow    = narrow_q;
  assign adc_data_narrow_d0 = narrow_d0_q;

endmodule
`default_nettype wire

// File: tb/tb_ad9226_sample.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ad9226_sample
//  Purpose  : Self-checking bench for ad9226_sample with a time-based
//             reference model (bursts located by trigger time arithmetic).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ad9226_sample;

  localparam int L = 16;
  localparam int H = 8;
  localparam int T = 127;

  logic        adc_clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] adc_data = 12'hFFF;
  logic        adc_buf_wr;
  logic [11:0] adc_buf_addr;
  logic [7:0]  adc_buf_data;
  logic [7:0]  adc_data_narrow;
  logic [7:0]  adc_data_narrow_d0;

  int total = 0;
  int bad   = 0;

  ad9226_sample #(.SAMPLE_LEN(L), .TRIG_LEVEL(T), .HOLDOFF(H)) dut (
    .adc_clk            (adc_clk),
    .rst                (rst),
    .adc_data           (adc_data),
    .adc_buf_wr         (adc_buf_wr),
    .adc_buf_addr       (adc_buf_addr),
    .adc_buf_data       (adc_buf_data),
    .adc_data_narrow    (adc_data_narrow),
    .adc_data_narrow_d0 (adc_data_narrow_d0)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Cycle c = value after the c-th rising edge since reset release.
  // A crossing seen while armed at cycle t yields writes at cycles
  // t+2 .. t+L+1 (addr = c-t-2, data = narrow of cycle c-1); the next
  // crossing may be accepted from cycle t+L+H+1 onwards.
  int          m_cyc, m_rearm, m_trig_t;
  logic [7:0]  m_nar, m_d0, m_prev;
  logic        m_wr;
  logic [11:0] m_addr;
  logic [7:0]  m_data;

  always @(posedge adc_clk) begin
    if (!rst) begin
      m_cyc = 0; m_rearm = 0; m_trig_t = -1000;
      m_nar = 8'd0; m_d0 = 8'd0; m_wr = 1'b0; m_addr = 12'd0; m_data = 8'd0;
    end else begin
      m_prev = m_nar;
      m_cyc  = m_cyc + 1;
      m_d0   = m_nar;
      m_nar  = adc_data[11:4];
      if (m_cyc >= m_trig_t + 2 && m_cyc <= m_trig_t + L + 1) begin
        m_wr   = 1'b1;
        m_addr = 12'(m_cyc - m_trig_t - 2);
        m_data = m_prev;
      end else begin
        m_wr = 1'b0;
      end
      if (m_cyc >= m_rearm && int'(m_d0) < T && int'(m_nar) >= T) begin
        m_trig_t = m_cyc;
        m_rearm  = m_cyc + L + H + 1;
      end
    end
  end

  // ---------------- compare + burst bookkeeping ----------------
  int          tcyc = 0;
  bit          in_burst = 0;
  int          blen = 0;
  logic [11:0] baddr_prev;
  int          bcount = 0;
  int          bstart[8];
  int          win_wr = 0;
  logic [7:0]  win_first_data, win_last_data;
  logic [11:0] win_last_addr;

  always @(posedge adc_clk) begin
    #1;
    tcyc++;
    chk("narrow", {24'd0, adc_data_narrow}, {24'd0, m_nar});
    chk("narrow_d0", {24'd0, adc_data_narrow_d0}, {24'd0, m_d0});
    chk("wr", {31'd0, adc_buf_wr}, {31'd0, m_wr});
    chk("addr", {20'd0, adc_buf_addr}, {20'd0, m_addr});
    chk("data", {24'd0, adc_buf_data}, {24'd0, m_data});
    if (!rst) begin
      in_burst = 0;
    end else if (adc_buf_wr) begin
      if (!in_burst) begin
        chk("burst_start_addr", {20'd0, adc_buf_addr}, 32'd0);
        if (bcount < 8) bstart[bcount] = tcyc;
        bcount++;
        in_burst = 1;
        blen = 1;
      end else begin
        chk("burst_addr_step", {20'd0, adc_buf_addr}, {20'd0, baddr_prev + 12'd1});
        blen++;
      end
      baddr_prev = adc_buf_addr;
      if (win_wr == 0) win_first_data = adc_buf_data;
      win_last_data = adc_buf_data;
      win_last_addr = adc_buf_addr;
      win_wr++;
    end else if (in_burst) begin
      chk("burst_len", blen, L);
      in_burst = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [7:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge adc_clk);
      adc_data = {v, 4'h9};
    end
  endtask

  initial begin
    bit found;

    // Reset held with full-scale input.
    repeat (3) @(negedge adc_clk);
    chk("rst_wr", {31'd0, adc_buf_wr}, 32'd0);
    chk("rst_addr", {20'd0, adc_buf_addr}, 32'd0);
    chk("rst_data", {24'd0, adc_buf_data}, 32'd0);
    chk("rst_narrow", {24'd0, adc_data_narrow}, 32'd0);
    chk("rst_d0", {24'd0, adc_data_narrow_d0}, 32'd0);
    rst = 1'b1;
    @(negedge adc_clk);
    chk("rel_narrow", {24'd0, adc_data_narrow}, 32'hFF);
    @(negedge adc_clk);
    chk("rel_d0", {24'd0, adc_data_narrow_d0}, 32'hFF);
    repeat (35) @(negedge adc_clk);

    // Narrowing by truncation.
    adc_data = 12'hABC;
    @(negedge adc_clk);
    chk("narrow_ABC", {24'd0, adc_data_narrow}, 32'hAB);
    @(negedge adc_clk);
    chk("d0_ABC", {24'd0, adc_data_narrow_d0}, 32'hAB);

    // Rising ramp: one burst of data 128..143.
    drive(8'd0, 30);
    win_wr = 0;
    for (int i = 0; i < 256; i++) drive(8'(i), 1);
    chk("ramp_writes", win_wr, L);
    chk("ramp_first_data", {24'd0, win_first_data}, 32'd128);
    chk("ramp_last_data", {24'd0, win_last_data}, 32'd143);
    chk("ramp_last_addr", {20'd0, win_last_addr}, 32'd15);

    // Falling ramp and constant level: no writes.
    win_wr = 0;
    for (int i = 200; i >= 0; i--) drive(8'(i), 1);
    drive(8'h50, 30);
    chk("no_trig_writes", win_wr, 0);

    // Square wave 0,0,255,255: bursts every 28 cycles, 4 in 112 cycles.
    win_wr = 0;
    bcount = 0;
    for (int i = 0; i < 112; i++) drive(((i % 4) < 2) ? 8'd0 : 8'd255, 1);
    drive(8'd0, 30);
    chk("hold_bursts", bcount, 4);
    chk("hold_writes", win_wr, 4 * L);
    chk("hold_spacing01", bstart[1] - bstart[0], 28);
    chk("hold_spacing23", bstart[3] - bstart[2], 28);

    // Reset in the middle of a burst.
    drive(8'd0, 5);
    drive(8'd255, 1);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge adc_clk);
      if (adc_buf_wr && adc_buf_addr == 12'd5) found = 1;
    end
    chk("wait_addr5", {31'd0, found}, 32'd1);
    adc_data = 12'h000;
    rst = 1'b0;
    #1;
    chk("abort_wr", {31'd0, adc_buf_wr}, 32'd0);
    chk("abort_addr", {20'd0, adc_buf_addr}, 32'd0);
    @(negedge adc_clk);
    rst = 1'b1;
    win_wr = 0;
    bcount = 0;
    drive(8'd0, 3);
    drive(8'd255, 1);
    drive(8'd255, 40);
    chk("restart_bursts", bcount, 1);
    chk("restart_writes", win_wr, L);
    chk("restart_last_addr", {20'd0, win_last_addr}, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
